button_event_arbiter: RTL and testbench

Debounces NUM_BTNS raw push-button inputs using one shared tick prescaler and one small counter per button. It turns the debounced levels into PRESS, RELEASE and LONG events. A round-robin arbiter serialises those events onto a single valid/ready event port that feeds the UI/control logic. Debounce semantics are the team's standard ones: a high input must be stable for the full window before the level rises, and a low input clears it immediately.

---
 rtl/button_event_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_button_event_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//   Debounces NUM_BTNS raw push buttons using one shared tick prescaler.
//   Each debounced level produces PRESS, RELEASE and LONG events, and a
//   round-robin arbiter serialises them onto one valid/ready event port.
//   If `BTN_AUTO_REPEAT_EN is defined, REPEAT events (type 3) are also
//   issued every REPEAT_TICKS ticks after LONG while the button stays held.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_in     raw asynchronous button inputs, active high
//   btn_level  debounced levels
//   evt_valid  event available
//   evt_ready  consumer accepts the event when evt_valid & evt_ready
//   evt_btn    index of the button that produced the event
//   evt_type   0=PRESS, 1=RELEASE, 2=LONG, 3=REPEAT
//   ovf        sticky per-button overflow flags
//   ovf_clr    one-cycle pulse clearing all ovf bits
module button_event_arbiter #(
  parameter int  NUM_BTNS       = 4,
  parameter int  TICK_DIV       = 1024,
  parameter int  DEBOUNCE_TICKS = 64,
  parameter int  LONG_TICKS     = 1000,
  parameter int  REPEAT_TICKS   = 200,
  localparam int BW             = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [BW-1:0]       evt_btn,
  output logic [1:0]          evt_type,
  output logic [NUM_BTNS-1:0] ovf,
  input  logic                ovf_clr
);

  if (NUM_BTNS < 1 || NUM_BTNS > 16 || TICK_DIV < 2 || DEBOUNCE_TICKS < 1 ||
      LONG_TICKS <= DEBOUNCE_TICKS || REPEAT_TICKS < 1) begin : g_param_check
    $error("button_event_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_t;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int NT = 4;
`else
  localparam int NT = 3;
`endif

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_TICKS);
  localparam logic [HW-1:0] LONG_MAX   = HW'(LONG_TICKS);

  // Pending bits are indexed by event type code.
  logic [NUM_BTNS-1:0] sync1, sync2;
  logic [PW-1:0]       presc;
  logic                tick;
  logic [DW-1:0]       deb_q  [NUM_BTNS];
  logic [DW-1:0]       deb_d  [NUM_BTNS];
  logic [HW-1:0]       hold_q [NUM_BTNS];
  logic [HW-1:0]       hold_d [NUM_BTNS];
  logic [NUM_BTNS-1:0] level_d;
  logic [NT-1:0]       det    [NUM_BTNS];
  logic [NT-1:0]       pend_q [NUM_BTNS];
  logic [NT-1:0]       pend_d [NUM_BTNS];
  logic [NT-1:0]       gnt    [NUM_BTNS];
  logic [NUM_BTNS-1:0] ovf_set;
  logic [BW-1:0]       ptr;
  logic [BW-1:0]       ptr_next;
  logic                found;
  logic                load;
  logic [BW-1:0]       gidx;
  logic [NT-1:0]       gpend;
  logic [NT-1:0]       gsel;
  evt_t                gtype;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_q [NUM_BTNS];
  logic [RW-1:0] rep_d [NUM_BTNS];
`endif

  assign tick = (presc == PRESC_LAST);

  // Per-button debounce, hold counting and event detection. Detection uses
  // the next-state level so a PRESS is pending on the same edge the level rises.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      deb_d[i]   = deb_q[i];
      level_d[i] = btn_level[i];
      hold_d[i]  = hold_q[i];
      det[i]     = '0;

      if (!sync2[i]) begin
        deb_d[i]   = '0;
        level_d[i] = 1'b0;
      end else if (tick && deb_q[i] != DEB_MAX) begin
        deb_d[i] = deb_q[i] + DW'(1);
        if (deb_d[i] == DEB_MAX) level_d[i] = 1'b1;
      end

      if (!btn_level[i]) begin
        hold_d[i] = '0;
      end else if (tick && hold_q[i] != LONG_MAX) begin
        hold_d[i] = hold_q[i] + HW'(1);
      end

      det[i][EVT_PRESS]   = level_d[i] & ~btn_level[i];
      det[i][EVT_RELEASE] = ~level_d[i] & btn_level[i];
      // Saturation at LONG_MAX makes this fire once per press.
      det[i][EVT_LONG]    = (hold_d[i] == LONG_MAX) && (hold_q[i] != LONG_MAX);

`ifdef BTN_AUTO_REPEAT_EN
      rep_d[i] = rep_q[i];
      if (!btn_level[i] || hold_q[i] != LONG_MAX) begin
        rep_d[i] = '0;
      end else if (tick) begin
        if (rep_q[i] == REP_LAST) begin
          rep_d[i]            = '0;
          det[i][EVT_REPEAT]  = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + RW'(1);
        end
      end
`endif
    end
  end

  // Round-robin: first requester at or above ptr, otherwise lowest overall.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    gpend = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      if (!found && (|pend_q[i]) && (i >= 32'(ptr))) begin
        found = 1'b1;
        gidx  = BW'(i);
        gpend = pend_q[i];
      end
    end
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      if (!found && (|pend_q[i])) begin
        found = 1'b1;
        gidx  = BW'(i);
        gpend = pend_q[i];
      end
    end

    gsel  = '0;
    gtype = EVT_PRESS;
    if (gpend[EVT_PRESS]) begin
      gsel[EVT_PRESS] = 1'b1;
      gtype           = EVT_PRESS;
    end else if (gpend[EVT_LONG]) begin
      gsel[EVT_LONG] = 1'b1;
      gtype          = EVT_LONG;
`ifdef BTN_AUTO_REPEAT_EN
    end else if (gpend[EVT_REPEAT]) begin
      gsel[EVT_REPEAT] = 1'b1;
      gtype            = EVT_REPEAT;
`endif
    end else if (gpend[EVT_RELEASE]) begin
      gsel[EVT_RELEASE] = 1'b1;
      gtype             = EVT_RELEASE;
    end

    load     = (!evt_valid || evt_ready) && found;
    ptr_next = (gidx == BW'(NUM_BTNS - 1)) ? '0 : gidx + BW'(1);
  end

  // A detection landing on a bit granted this cycle re-arms it without overflow.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      gnt[i]     = (load && gidx == BW'(i)) ? gsel : '0;
      pend_d[i]  = (pend_q[i] & ~gnt[i]) | det[i];
      ovf_set[i] = |(det[i] & pend_q[i] & ~gnt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      presc     <= '0;
      btn_level <= '0;
      ovf       <= '0;
      evt_valid <= 1'b0;
      evt_btn   <= '0;
      evt_type  <= '0;
      ptr       <= '0;
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        deb_q[i]  <= '0;
        hold_q[i] <= '0;
        pend_q[i] <= '0;
`ifdef BTN_AUTO_REPEAT_EN
        rep_q[i]  <= '0;
`endif
      end
    end else begin
      sync1     <= btn_in;
      sync2     <= sync1;
      presc     <= tick ? '0 : presc + PW'(1);
      btn_level <= level_d;
      ovf       <= (ovf & ~{NUM_BTNS{ovf_clr}}) | ovf_set;
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        deb_q[i]  <= deb_d[i];
        hold_q[i] <= hold_d[i];
        pend_q[i] <= pend_d[i];
`ifdef BTN_AUTO_REPEAT_EN
        rep_q[i]  <= rep_d[i];
`endif
      end
      if (load) begin
        evt_valid <= 1'b1;
        evt_btn   <= gidx;
        evt_type  <= gtype;
        ptr       <= ptr_next;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;

  localparam logic [1:0] T_PRESS = 2'd0;
  localparam logic [1:0] T_REL   = 2'd1;
  localparam logic [1:0] T_LONG  = 2'd2;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic [3:0] btn_in  = '0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic [1:0] evt_btn;
  logic [1:0] evt_type;
  logic [3:0] ovf;

  int errors = 0;
  int checks = 0;

  // Expected delivered events: {btn, type}
  logic [3:0] exp_q[$];

  button_event_arbiter #(
    .NUM_BTNS      (4),
    .TICK_DIV      (4),
    .DEBOUNCE_TICKS(3),
    .LONG_TICKS    (8),
    .REPEAT_TICKS  (200)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_btn  (evt_btn),
    .evt_type (evt_type),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Handshakes are observed mid-cycle; inputs only change 1 ns after posedge.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got btn=%0d type=%0d, expected no event", evt_btn, evt_type);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if ({evt_btn, evt_type} !== e) begin
          errors++;
          $display("FAIL event_order: got btn=%0d type=%0d, expected btn=%0d type=%0d",
                   evt_btn, evt_type, e[3:2], e[1:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    step(3);
    checks++;
    if (btn_level !== 4'b0000) begin errors++; $display("FAIL reset_level: got %b expected 0000", btn_level); end
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    checks++;
    if (evt_btn !== 2'd0) begin errors++; $display("FAIL reset_btn: got %0d expected 0", evt_btn); end
    checks++;
    if (evt_type !== 2'd0) begin errors++; $display("FAIL reset_type: got %0d expected 0", evt_type); end
    checks++;
    if (ovf !== 4'b0000) begin errors++; $display("FAIL reset_ovf: got %b expected 0000", ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_press_latency();
    int n;
    evt_ready = 1'b1;
    exp_q.push_back({2'd2, T_PRESS});
    btn_in[2] = 1'b1;
    n = 0;
    while (btn_level[2] !== 1'b1 && n < 20) begin step(1); n++; end
    checks++;
    if (n < 11 || n > 14) begin errors++; $display("FAIL press_debounce_time: got %0d cycles expected 11..14", n); end
    step(1);
    checks++;
    if ({evt_valid, evt_btn, evt_type} !== {1'b1, 2'd2, T_PRESS}) begin
      errors++;
      $display("FAIL press_latency: got valid=%b btn=%0d type=%0d expected valid=1 btn=2 type=0",
               evt_valid, evt_btn, evt_type);
    end
    exp_q.push_back({2'd2, T_REL});
    btn_in[2] = 1'b0;
    step(3);
    checks++;
    if (btn_level[2] !== 1'b0) begin errors++; $display("FAIL release_fast: got %b expected 0", btn_level[2]); end
    step(10);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL press_release_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  // Two short glitches back to back: each fits in at most 2 ticks, so the
  // level only rises if the counter fails to clear between them.
  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    repeat (2) begin
      btn_in[0] = 1'b1;
      repeat (6) begin step(1); if (btn_level[0]) seen = 1'b1; end
      btn_in[0] = 1'b0;
      repeat (4) begin step(1); if (btn_level[0]) seen = 1'b1; end
    end
    step(10);
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL glitch_level: got level high expected stays 0"); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_queue: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_long();
    int n;
    exp_q.push_back({2'd1, T_PRESS});
    exp_q.push_back({2'd1, T_LONG});
    btn_in[1] = 1'b1;
    n = 0;
    while (btn_level[1] !== 1'b1 && n < 20) begin step(1); n++; end
    checks++;
    if (n > 14) begin errors++; $display("FAIL long_debounce: got %0d cycles expected <=14", n); end
    step(28);
    checks++;
    if (exp_q.size() != 1) begin errors++; $display("FAIL long_not_early: got %0d pending expected 1", exp_q.size()); end
    step(6);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL long_on_time: got %0d pending expected 0", exp_q.size()); end
    step(14);
    exp_q.push_back({2'd1, T_REL});
    btn_in[1] = 1'b0;
    step(20);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL long_release: got %0d pending expected 0", exp_q.size()); end
    checks++;
    if (btn_level !== 4'b0000) begin errors++; $display("FAIL long_level_end: got %b expected 0000", btn_level); end
  endtask

  task automatic test_round_robin();
    int n;
    apply_reset();
    evt_ready = 1'b0;
    exp_q.push_back({2'd0, T_PRESS});
    exp_q.push_back({2'd1, T_PRESS});
    exp_q.push_back({2'd3, T_PRESS});
    btn_in = 4'b1011;
    n = 0;
    while (btn_level !== 4'b1011 && n < 20) begin step(1); n++; end
    checks++;
    if (btn_level !== 4'b1011) begin errors++; $display("FAIL rr_levels: got %b expected 1011", btn_level); end
    step(1);
    repeat (20) begin
      step(1);
      checks++;
      if ({evt_valid, evt_btn, evt_type} !== {1'b1, 2'd0, T_PRESS}) begin
        errors++;
        $display("FAIL rr_hold_stable: got valid=%b btn=%0d type=%0d expected valid=1 btn=0 type=0",
                 evt_valid, evt_btn, evt_type);
      end
    end
    evt_ready = 1'b1;
    step(1);
    checks++;
    if ({evt_valid, evt_btn} !== {1'b1, 2'd1}) begin errors++; $display("FAIL rr_second: got valid=%b btn=%0d expected valid=1 btn=1", evt_valid, evt_btn); end
    step(1);
    checks++;
    if ({evt_valid, evt_btn} !== {1'b1, 2'd3}) begin errors++; $display("FAIL rr_third: got valid=%b btn=%0d expected valid=1 btn=3", evt_valid, evt_btn); end
    step(1);
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got valid=%b expected 0", evt_valid); end
    // Pointer has wrapped to 0, so simultaneous releases come out 0,1,3.
    exp_q.push_back({2'd0, T_REL});
    exp_q.push_back({2'd1, T_REL});
    exp_q.push_back({2'd3, T_REL});
    btn_in = 4'b0000;
    step(15);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rr_release: got %0d pending expected 0", exp_q.size()); end
  endtask

  // PRESS#1 sits in the output register, RELEASE#1 and PRESS#2 go pending,
  // RELEASE#2 collides with the still-pending RELEASE and overflows.
  task automatic test_overflow();
    int n;
    evt_ready = 1'b0;
    repeat (2) begin
      btn_in[2] = 1'b1;
      n = 0;
      while (btn_level[2] !== 1'b1 && n < 20) begin step(1); n++; end
      btn_in[2] = 1'b0;
      n = 0;
      while (btn_level[2] !== 1'b0 && n < 10) begin step(1); n++; end
    end
    step(3);
    checks++;
    if (ovf !== 4'b0100) begin errors++; $display("FAIL ovf_set: got %b expected 0100", ovf); end
    checks++;
    if ({evt_valid, evt_btn, evt_type} !== {1'b1, 2'd2, T_PRESS}) begin
      errors++;
      $display("FAIL ovf_output_held: got valid=%b btn=%0d type=%0d expected valid=1 btn=2 type=0",
               evt_valid, evt_btn, evt_type);
    end
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clear: got %b expected 0000", ovf); end
    exp_q.push_back({2'd2, T_PRESS});
    exp_q.push_back({2'd2, T_PRESS});
    exp_q.push_back({2'd2, T_REL});
    evt_ready = 1'b1;
    step(10);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    evt_ready = 1'b0;
    btn_in = 4'b1001;
    n = 0;
    while (btn_level !== 4'b1001 && n < 20) begin step(1); n++; end
    step(2);
    checks++;
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", evt_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({btn_level, evt_valid, evt_btn, evt_type, ovf} !== 13'd0) begin
      errors++;
      $display("FAIL mid_async_reset: got level=%b valid=%b btn=%0d type=%0d ovf=%b expected all 0",
               btn_level, evt_valid, evt_btn, evt_type, ovf);
    end
    btn_in[0] = 1'b0;
    step(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    exp_q.push_back({2'd3, T_PRESS});
    n = 0;
    while (btn_level[3] !== 1'b1 && n < 20) begin step(1); n++; end
    checks++;
    if (n != 12) begin errors++; $display("FAIL mid_full_debounce: got %0d cycles expected 12", n); end
    step(1);
    checks++;
    if ({evt_valid, evt_btn, evt_type} !== {1'b1, 2'd3, T_PRESS}) begin
      errors++;
      $display("FAIL mid_press: got valid=%b btn=%0d type=%0d expected valid=1 btn=3 type=0",
               evt_valid, evt_btn, evt_type);
    end
    exp_q.push_back({2'd3, T_REL});
    btn_in[3] = 1'b0;
    step(15);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mid_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_long();
    test_round_robin();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
